gpio_bus_master: RTL and testbench
==================================

# gpio_bus_master

Bus initiator for the memory-mapped GPIO peripheral bus: converts single-cycle CPU-side requests into CS_N/RD_N/WR_N strobe cycles with programmable setup, strobe and hold lengths, and returns read data with a one-cycle acknowledge. Read strobes are exactly one cycle, so read-to-clear status registers (KEY, SW) are captured and cleared exactly once per read. It also registers the peripheral's active-low interrupt into an active-high level for the CPU. Sits between the processor's data-memory port and the GPIO block.

## Interface
- SETUP_CYCLES, 1, cycles CS_N low with strobes high before strobe (0–15; 0 skips SETUP)
- WR_CYCLES, 1, WR_N low length (1–15); read strobe is fixed at 1
- HOLD_CYCLES, 1, cycles CS_N low with strobes high after strobe (0–15; 0 skips HOLD)

- CLOCK_50  in  1  clock, all logic on rising edge
- reset  in  1  one clock; reset is synchronous and active-low
- req  in  1  request, sampled only in IDLE
- we  in  1  1 = write, 0 = read
- addr  in  12  byte address
- wdata  in  32  write data
- busy  out  1  high in every state except IDLE
- ack  out  1  one-cycle completion pulse
- err  out  1  valid with ack; 1 = misaligned request, no bus cycle issued
- rdata  out  32  captured read data
- irq  out  1  registered ~Intr
- CS_N, RD_N, WR_N  out  1 each  active-low bus strobes
- Addr  out  12  bus address
- bus_wdata  out  32  drives peripheral DataIn
- bus_rdata  in  32  from peripheral DataOut (combinational in peripheral)
- Intr  in  1  peripheral interrupt, active low

## Operation
- States: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE: CS_N=RD_N=WR_N=1. On req=1 latch we/addr/wdata. If addr[1:0]≠0 go DONE with err=1; else go SETUP (or STROBE if SETUP_CYCLES=0).
- SETUP: CS_N=0, RD_N=WR_N=1, Addr/bus_wdata from latched values; stay SETUP_CYCLES cycles.
- STROBE: CS_N=0; read: RD_N=0 for exactly 1 cycle, rdata <= bus_rdata on the edge ending that cycle; write: WR_N=0 for WR_CYCLES cycles.
- HOLD: CS_N=0, strobes high, HOLD_CYCLES cycles (skipped if 0).
- DONE: CS_N=1, ack=1, err per request; next state IDLE unconditionally.
- req outside IDLE is ignored (no queueing); requester must hold or re-issue.
- rdata holds until the next successful read completes; writes and err cycles do not alter it.
- RD_N and WR_N never low simultaneously; neither low while CS_N high.
- One 4-bit down-counter reused across SETUP/STROBE/HOLD; loaded on state entry.

## Timing
- Reset (reset=0 at an edge): state IDLE, CS_N=RD_N=WR_N=1, Addr=0, bus_wdata=0, rdata=0, ack=0, err=0, busy=0, irq=0, counter=0. Applies mid-transaction: strobes deassert at that edge, no ack for the aborted request.
- Acceptance edge E0. ack high during the cycle after edge E(SETUP_CYCLES + T + HOLD_CYCLES), T=1 read, WR_CYCLES write. Defaults: read ack after E3, write ack after E3.
- Misaligned: ack=err=1 in the cycle after E0; no strobe of any kind.
- Minimum request-to-request spacing: next req accepted in the IDLE cycle following DONE.
- irq = registered ~Intr, one cycle latency, no edge detection.
- All outputs registered; no combinational path from req or bus_rdata to any output.

## Structure
- Package gpio_bus_pkg: state enum; GPIO register offsets (KEY 0x000, SW 0x004, LEDR 0x008, LEDG 0x00C, HEX0..HEX7 0x010–0x02C); counter width constant (4).
- Single module; no sub-module.

## Test plan
- Defaults, GPIO responder attached, KEY1 debounced press then read 0x000 -> RD_N low exactly 1 cycle, ack after E3, rdata=0x0000_0002, KEY status 0 afterward; second read -> rdata=0.
- Write 0x008 data 0x0003_FFFF, WR_CYCLES=3 -> WR_N low 3 cycles, CS_N low 5 cycles, ack after E5, LEDR all on.
- SETUP_CYCLES=0, HOLD_CYCLES=0, read 0x004 -> CS_N low 1 cycle coincident with RD_N, ack after E1.
- Request addr 0x006 -> ack=err=1 cycle after E0, CS_N never low, rdata unchanged.
- reset=0 during STROBE of a write -> strobes high at that edge, no ack, all outputs at reset values; new request afterward completes normally.
- req held high through a transaction and Intr toggled -> exactly one bus cycle per IDLE acceptance, irq follows ~Intr one cycle late.

Source files
------------

// File: rtl/gpio_bus_pkg.sv
// rtl/gpio_bus_pkg.sv - shared types and GPIO register map for the bus master
package gpio_bus_pkg;

   // Width of the shared setup/strobe/hold down-counter
   localparam int CNT_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD,
      ST_DONE
   } state_t;

   // GPIO peripheral register byte offsets
   localparam logic [11:0] OFS_KEY  = 12'h000;
   localparam logic [11:0] OFS_SW   = 12'h004;
   localparam logic [11:0] OFS_LEDR = 12'h008;
   localparam logic [11:0] OFS_LEDG = 12'h00C;
   localparam logic [11:0] OFS_HEX0 = 12'h010;
   localparam logic [11:0] OFS_HEX1 = 12'h014;
   localparam logic [11:0] OFS_HEX2 = 12'h018;
   localparam logic [11:0] OFS_HEX3 = 12'h01C;
   localparam logic [11:0] OFS_HEX4 = 12'h020;
   localparam logic [11:0] OFS_HEX5 = 12'h024;
   localparam logic [11:0] OFS_HEX6 = 12'h028;
   localparam logic [11:0] OFS_HEX7 = 12'h02C;

endpackage

// File: rtl/gpio_bus_master.sv
// rtl/gpio_bus_master.sv - CPU request to CS_N/RD_N/WR_N strobe-cycle bus initiator
module gpio_bus_master
   import gpio_bus_pkg::*;
#(
   parameter int SETUP_CYCLES = 1,
   parameter int WR_CYCLES    = 1,
   parameter int HOLD_CYCLES  = 1
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [11:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        ack,
   output logic        err,
   output logic [31:0] rdata,
   output logic        irq,
   output logic        CS_N,
   output logic        RD_N,
   output logic        WR_N,
   output logic [11:0] Addr,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        Intr
);

   // Counter reload values: the counter holds "cycles remaining minus one"
   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'((SETUP_CYCLES > 0) ? SETUP_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0] WR_LD    = CNT_W'((WR_CYCLES > 0) ? WR_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               we_q, we_nxt;
   logic               mis_q, mis_nxt;
   logic [11:0]        addr_nxt;
   logic [31:0]        wdata_nxt;
   logic               capture;

   // Next-state, counter reload and request latching
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      we_nxt    = we_q;
      mis_nxt   = mis_q;
      addr_nxt  = Addr;
      wdata_nxt = bus_wdata;
      capture   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (req) begin
               we_nxt    = we;
               addr_nxt  = addr;
               wdata_nxt = wdata;
               mis_nxt   = (addr[1:0] != 2'b00);
               if (addr[1:0] != 2'b00) begin
                  state_nxt = ST_DONE;
                  cnt_nxt   = '0;
               end else if (SETUP_CYCLES > 0) begin
                  state_nxt = ST_SETUP;
                  cnt_nxt   = SETUP_LD;
               end else begin
                  state_nxt = ST_STROBE;
                  cnt_nxt   = we ? WR_LD : '0;
               end
            end
         end
         ST_SETUP: begin
            if (cnt == '0) begin
               state_nxt = ST_STROBE;
               cnt_nxt   = we_q ? WR_LD : '0;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         ST_STROBE: begin
            if (cnt == '0) begin
               capture = !we_q;
               if (HOLD_CYCLES > 0) begin
                  state_nxt = ST_HOLD;
                  cnt_nxt   = HOLD_LD;
               end else begin
                  state_nxt = ST_DONE;
                  cnt_nxt   = '0;
               end
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         ST_HOLD: begin
            if (cnt == '0) begin
               state_nxt = ST_DONE;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // State, counter and latched request registers
   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         we_q      <= 1'b0;
         mis_q     <= 1'b0;
         Addr      <= '0;
         bus_wdata <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         we_q      <= we_nxt;
         mis_q     <= mis_nxt;
         Addr      <= addr_nxt;
         bus_wdata <= wdata_nxt;
      end
   end

   // Registered strobes and handshake, decoded from the state being entered
   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         CS_N  <= 1'b1;
         RD_N  <= 1'b1;
         WR_N  <= 1'b1;
         ack   <= 1'b0;
         err   <= 1'b0;
         busy  <= 1'b0;
         rdata <= '0;
      end else begin
         CS_N  <= !(state_nxt inside {ST_SETUP, ST_STROBE, ST_HOLD});
         RD_N  <= !((state_nxt == ST_STROBE) && !we_nxt);
         WR_N  <= !((state_nxt == ST_STROBE) && we_nxt);
         ack   <= (state_nxt == ST_DONE);
         err   <= (state_nxt == ST_DONE) && mis_nxt;
         busy  <= (state_nxt != ST_IDLE);
         if (capture) begin
            rdata <= bus_rdata;
         end
      end
   end

   // Interrupt level: invert the active-low peripheral line with one register stage
   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         irq <= 1'b0;
      end else begin
         irq <= ~Intr;
      end
   end

endmodule

// File: tb/tb_gpio_bus_master.sv
// tb/tb_gpio_bus_master.sv - randomized model-checked bench for gpio_bus_master
module tb_gpio_bus_master;
   import gpio_bus_pkg::*;

   localparam int NI = 3;

   // Per-instance timing configuration: {setup, write strobe, hold}
   int cfg_s [NI] = '{1, 1, 0};
   int cfg_w [NI] = '{1, 3, 1};
   int cfg_h [NI] = '{1, 1, 0};

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic        rstn      [NI];
   logic        req       [NI];
   logic        we        [NI];
   logic [11:0] addr      [NI];
   logic [31:0] wdata     [NI];
   logic        intr      [NI];
   logic        busy      [NI];
   logic        ack       [NI];
   logic        err       [NI];
   logic [31:0] rdata     [NI];
   logic        irq       [NI];
   logic        cs_n      [NI];
   logic        rd_n      [NI];
   logic        wr_n      [NI];
   logic [11:0] baddr     [NI];
   logic [31:0] bwdata    [NI];
   logic [31:0] bus_rdata [NI];

   logic [31:0] rr      [NI][12];
   logic [31:0] key_set [NI];
   logic [31:0] sw_set  [NI];
   logic        por   = 1'b1;
   logic        armed = 1'b0;

   int total = 0;
   int bad   = 0;

   gpio_bus_master #(.SETUP_CYCLES(1), .WR_CYCLES(1), .HOLD_CYCLES(1)) u_dut0 (
      .CLOCK_50(clk), .reset(rstn[0]), .req(req[0]), .we(we[0]), .addr(addr[0]),
      .wdata(wdata[0]), .busy(busy[0]), .ack(ack[0]), .err(err[0]), .rdata(rdata[0]),
      .irq(irq[0]), .CS_N(cs_n[0]), .RD_N(rd_n[0]), .WR_N(wr_n[0]), .Addr(baddr[0]),
      .bus_wdata(bwdata[0]), .bus_rdata(bus_rdata[0]), .Intr(intr[0]));

   gpio_bus_master #(.SETUP_CYCLES(1), .WR_CYCLES(3), .HOLD_CYCLES(1)) u_dut1 (
      .CLOCK_50(clk), .reset(rstn[1]), .req(req[1]), .we(we[1]), .addr(addr[1]),
      .wdata(wdata[1]), .busy(busy[1]), .ack(ack[1]), .err(err[1]), .rdata(rdata[1]),
      .irq(irq[1]), .CS_N(cs_n[1]), .RD_N(rd_n[1]), .WR_N(wr_n[1]), .Addr(baddr[1]),
      .bus_wdata(bwdata[1]), .bus_rdata(bus_rdata[1]), .Intr(intr[1]));

   gpio_bus_master #(.SETUP_CYCLES(0), .WR_CYCLES(1), .HOLD_CYCLES(0)) u_dut2 (
      .CLOCK_50(clk), .reset(rstn[2]), .req(req[2]), .we(we[2]), .addr(addr[2]),
      .wdata(wdata[2]), .busy(busy[2]), .ack(ack[2]), .err(err[2]), .rdata(rdata[2]),
      .irq(irq[2]), .CS_N(cs_n[2]), .RD_N(rd_n[2]), .WR_N(wr_n[2]), .Addr(baddr[2]),
      .bus_wdata(bwdata[2]), .bus_rdata(bus_rdata[2]), .Intr(intr[2]));

   task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s inst=%0d t=%0t got=%h want=%h", nm, inst, $time, act, want);
      end
   endtask

   // GPIO responder: combinational read port
   always_comb begin
      for (int i = 0; i < NI; i++) begin
         int ridx;
         ridx = int'(baddr[i][5:2]);
         bus_rdata[i] = (ridx < 12) ? rr[i][ridx] : 32'h0;
      end
   end

   // GPIO responder: writes, read-to-clear KEY/SW, button and switch events
   always @(posedge clk) begin
      for (int i = 0; i < NI; i++) begin
         int widx;
         widx = int'(baddr[i][5:2]);
         if (por) begin
            for (int r = 0; r < 12; r++) rr[i][r] <= 32'h0;
         end else begin
            if (!cs_n[i] && !wr_n[i] && widx < 12) rr[i][widx] <= bwdata[i];
            else if (!cs_n[i] && !rd_n[i] && widx < 2) rr[i][widx] <= 32'h0;
            if (key_set[i] != 0) rr[i][0] <= rr[i][0] | key_set[i];
            if (sw_set[i] != 0) rr[i][1] <= rr[i][1] | sw_set[i];
         end
      end
   end

   // Behavioural model: transaction timeline as offsets from the acceptance edge
   bit          m_act  [NI];
   int          m_k    [NI];
   int          m_n    [NI];
   bit          m_we   [NI];
   bit          m_mis  [NI];
   logic [11:0] m_addr [NI];
   logic [31:0] m_wd   [NI];
   logic [31:0] m_rd   [NI];
   logic [31:0] m_pend [NI];
   logic        m_irq  [NI];
   logic [31:0] sh     [NI][12];

   initial begin
      for (int i = 0; i < NI; i++) begin
         m_act[i] = 0; m_k[i] = 0; m_n[i] = 0; m_we[i] = 0; m_mis[i] = 0;
         m_addr[i] = 0; m_wd[i] = 0; m_rd[i] = 0; m_pend[i] = 0; m_irq[i] = 0;
         for (int r = 0; r < 12; r++) sh[i][r] = 0;
      end
      forever begin
         @(posedge clk);
         for (int i = 0; i < NI; i++) begin
            if (por) for (int r = 0; r < 12; r++) sh[i][r] = 0;
            sh[i][0] = sh[i][0] | key_set[i];
            sh[i][1] = sh[i][1] | sw_set[i];
            if (!rstn[i]) begin
               m_act[i] = 0; m_addr[i] = 0; m_wd[i] = 0; m_rd[i] = 0; m_irq[i] = 0;
            end else begin
               m_irq[i] = ~intr[i];
               if (m_act[i]) begin
                  if (!m_we[i] && !m_mis[i] && m_k[i] == cfg_s[i]) m_rd[i] = m_pend[i];
                  if (m_k[i] == m_n[i]) m_act[i] = 0;
                  else m_k[i] = m_k[i] + 1;
               end else if (req[i]) begin
                  int idx;
                  m_act[i] = 1; m_k[i] = 0;
                  m_we[i] = we[i]; m_addr[i] = addr[i]; m_wd[i] = wdata[i];
                  m_mis[i] = (addr[i] % 4) != 0;
                  m_n[i] = m_mis[i] ? 0 : cfg_s[i] + (we[i] ? cfg_w[i] : 1) + cfg_h[i];
                  idx = int'(addr[i]) / 4;
                  if (!m_mis[i]) begin
                     if (we[i]) sh[i][idx] = wdata[i];
                     else begin
                        m_pend[i] = sh[i][idx];
                        if (idx < 2) sh[i][idx] = 0;
                     end
                  end
               end
            end
         end
      end
   end

   // Compare every output of every instance against the model each cycle
   always @(negedge clk) begin
      if (armed) begin
         for (int i = 0; i < NI; i++) begin
            bit a;
            int k;
            a = m_act[i];
            k = m_k[i];
            chk("cs_n", i, cs_n[i], !(a && k < m_n[i]));
            chk("rd_n", i, rd_n[i], !(a && !m_we[i] && !m_mis[i] && k == cfg_s[i]));
            chk("wr_n", i, wr_n[i], !(a && m_we[i] && !m_mis[i] && k >= cfg_s[i] && k < cfg_s[i] + cfg_w[i]));
            chk("ack", i, ack[i], a && k == m_n[i]);
            chk("err", i, err[i], a && k == m_n[i] && m_mis[i]);
            chk("busy", i, busy[i], a);
            chk("rdata", i, rdata[i], m_rd[i]);
            chk("addr", i, baddr[i], m_addr[i]);
            chk("bus_wdata", i, bwdata[i], m_wd[i]);
            chk("irq", i, irq[i], m_irq[i]);
         end
      end
   end

   // Peripheral interrupt lines toggle at random
   initial begin
      for (int i = 0; i < NI; i++) intr[i] = 1'b1;
      repeat (4) @(negedge clk);
      forever begin
         @(negedge clk);
         for (int i = 0; i < NI; i++) if ($urandom_range(0, 3) == 0) intr[i] = ~intr[i];
      end
   end

   task automatic txn(input int i, input bit w, input logic [11:0] a, input logic [31:0] d,
                      output int lat, output int ncs, output int nrd, output int nwr, output bit saw_err);
      int guard;
      guard = 0;
      while (busy[i] && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
      lat = 0; ncs = 0; nrd = 0; nwr = 0; saw_err = 0;
      do begin
         @(negedge clk);
         lat++;
         if (!cs_n[i]) ncs++;
         if (!rd_n[i]) nrd++;
         if (!wr_n[i]) nwr++;
         if (ack[i]) saw_err = err[i];
      end while (!ack[i] && lat < 60);
      req[i] = 1'b0;
      chk("ack_seen", i, ack[i], 1);
   endtask

   task automatic pulse_inputs(input int i, input logic [31:0] k, input logic [31:0] s);
      key_set[i] = k; sw_set[i] = s;
      @(negedge clk);
      key_set[i] = 0; sw_set[i] = 0;
   endtask

   task automatic rand_run(input int i, input int n);
      int guard;
      for (int t = 0; t < n; t++) begin
         int idx;
         logic [11:0] a;
         if ($urandom_range(0, 3) == 0) pulse_inputs(i, $urandom_range(0, 15), $urandom_range(0, 1023));
         if (!req[i]) repeat ($urandom_range(0, 2)) @(negedge clk);
         idx = $urandom_range(0, 11);
         a = 12'(idx * 4);
         if ($urandom_range(0, 7) == 0) a = a + 12'($urandom_range(1, 3));
         req[i] = 1'b1; we[i] = $urandom_range(0, 1) == 1; addr[i] = a; wdata[i] = $urandom;
         guard = 0;
         do begin
            @(negedge clk);
            guard++;
         end while (!ack[i] && guard < 80);
         chk("rand_ack_seen", i, ack[i], 1);
         if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
      end
      req[i] = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int lat, ncs, nrd, nwr, guard;
      bit se;
      for (int i = 0; i < NI; i++) begin
         rstn[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
         key_set[i] = '0; sw_set[i] = '0;
      end
      @(posedge clk);
      armed = 1'b1;
      @(negedge clk);
      @(negedge clk);
      por = 1'b0;
      for (int i = 0; i < NI; i++) rstn[i] = 1'b1;
      @(negedge clk);

      // Reset state pinned to literals
      chk("rst_cs_n", 0, cs_n[0], 1);
      chk("rst_rdata", 0, rdata[0], 0);
      chk("rst_busy", 0, busy[0], 0);

      // KEY1 press then read-to-clear on default timing
      pulse_inputs(0, 32'h2, 32'h0);
      txn(0, 1'b0, OFS_KEY, 32'h0, lat, ncs, nrd, nwr, se);
      chk("key_lat", 0, lat, 4);
      chk("key_rd_low", 0, nrd, 1);
      chk("key_cs_low", 0, ncs, 3);
      chk("key_rdata", 0, rdata[0], 32'h2);
      chk("key_cleared", 0, rr[0][0], 0);
      txn(0, 1'b0, OFS_KEY, 32'h0, lat, ncs, nrd, nwr, se);
      chk("key_rdata2", 0, rdata[0], 32'h0);

      // LEDR write with a three-cycle write strobe
      txn(1, 1'b1, OFS_LEDR, 32'h0003_FFFF, lat, ncs, nrd, nwr, se);
      chk("ledr_lat", 1, lat, 6);
      chk("ledr_wr_low", 1, nwr, 3);
      chk("ledr_cs_low", 1, ncs, 5);
      chk("ledr_reg", 1, rr[1][2], 32'h0003_FFFF);

      // Zero setup/hold read, then a misaligned request
      pulse_inputs(2, 32'h0, 32'h155);
      txn(2, 1'b0, OFS_SW, 32'h0, lat, ncs, nrd, nwr, se);
      chk("sw_lat", 2, lat, 2);
      chk("sw_cs_low", 2, ncs, 1);
      chk("sw_rd_low", 2, nrd, 1);
      chk("sw_rdata", 2, rdata[2], 32'h155);
      txn(2, 1'b0, 12'h006, 32'h0, lat, ncs, nrd, nwr, se);
      chk("mis_lat", 2, lat, 1);
      chk("mis_err", 2, se, 1);
      chk("mis_cs_low", 2, ncs, 0);
      chk("mis_rdata", 2, rdata[2], 32'h155);

      // Randomized traffic with held and re-issued requests
      for (int i = 0; i < NI; i++) rand_run(i, 60);

      // Reset during the write strobe aborts the transaction
      req[1] = 1'b1; we[1] = 1'b1; addr[1] = OFS_HEX7; wdata[1] = 32'h1234_5678;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (wr_n[1] && guard < 20);
      chk("abort_wr_seen", 1, wr_n[1], 0);
      rstn[1] = 1'b0; req[1] = 1'b0;
      @(negedge clk);
      chk("abort_cs_n", 1, cs_n[1], 1);
      chk("abort_wr_n", 1, wr_n[1], 1);
      chk("abort_ack", 1, ack[1], 0);
      chk("abort_busy", 1, busy[1], 0);
      chk("abort_rdata", 1, rdata[1], 0);
      chk("abort_addr", 1, baddr[1], 0);
      rstn[1] = 1'b1;
      repeat (6) @(negedge clk);
      txn(1, 1'b1, OFS_HEX7, 32'h0000_A5A5, lat, ncs, nrd, nwr, se);
      chk("post_wr_lat", 1, lat, 6);
      txn(1, 1'b0, OFS_HEX7, 32'h0, lat, ncs, nrd, nwr, se);
      chk("post_rd_lat", 1, lat, 4);
      chk("post_rdata", 1, rdata[1], 32'h0000_A5A5);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
